// File: rtl/bpm_pkg.sv
// bpm_pkg: shared state, period type and time constant for the BPM beat generator
package bpm_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_DIV, RUN} state_t;
  typedef logic [31:0] period_t;
  localparam int SEC_PER_MIN = 60;
endpackage

// File: rtl/bpm_period_divider.sv
// bpm_period_divider: 32-step unsigned restoring divider, abortable by synchronous reset
module bpm_period_divider
  import bpm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output period_t     quotient
);
  logic [15:0] rem;
  logic [15:0] dsr;
  logic [5:0]  cnt;
  logic [16:0] shifted;
  logic        borrow;
  assign shifted = {rem, quotient[31]};
  assign borrow  = shifted < {1'b0, dsr};
  assign done    = busy && cnt == 6'd0;
  // one quotient bit per cycle; the extra cycle after the last bit hands the result over
  always_ff @(posedge clk)
    if (reset) begin
      busy     <= 1'b0;
      cnt      <= 6'd0;
      rem      <= 16'd0;
      dsr      <= 16'd0;
      quotient <= '0;
    end else if (start && !busy) begin
      busy     <= 1'b1;
      cnt      <= 6'd32;
      rem      <= 16'd0;
      dsr      <= divisor;
      quotient <= dividend;
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      rem      <= borrow ? shifted[15:0] : 16'(shifted - {1'b0, dsr});
      quotient <= {quotient[30:0], !borrow};
      cnt      <= cnt - 6'd1;
    end
endmodule

// File: rtl/bpm_beat_generator.sv
// bpm_beat_generator: regenerates a beat/bar tick train from a BPM value; define BEAT_SYNC_EN for sync_pulse phase realignment
module bpm_beat_generator
  import bpm_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int MIN_BPM       = 40,
  parameter int MAX_BPM       = 240,
  parameter int BEATS_PER_BAR = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bpm_in,
  input  logic        bpm_valid,
  output logic        bpm_ready,
  input  logic        sync_pulse,
  output logic        beat_tick,
  output logic        bar_start,
  output logic [3:0]  beat_in_bar,
  output period_t     period_cycles,
  output logic        running
);
  localparam period_t DIVIDEND = period_t'(64'(SEC_PER_MIN) * 64'(CLK_HZ));
  state_t      state, next_state;
  period_t     cnt, active_period, quotient;
  logic        div_busy, div_done;
  logic        accept, stop, start_div, wrap, tick_now, zero_cnt;
  logic [15:0] bpm_clamped;
  logic [3:0]  bar_next;
  assign bpm_ready   = !div_busy;
  assign accept      = bpm_valid && bpm_ready;
  assign stop        = accept && bpm_in == 16'd0;
  assign start_div   = accept && bpm_in != 16'd0;
  assign bpm_clamped = bpm_in < 16'(MIN_BPM) ? 16'(MIN_BPM) : bpm_in > 16'(MAX_BPM) ? 16'(MAX_BPM) : bpm_in;
  assign running     = state == RUN;
  assign wrap        = cnt == active_period - 32'd1;
  assign bar_next    = beat_in_bar == 4'(BEATS_PER_BAR - 1) ? 4'd0 : beat_in_bar + 4'd1;
`ifdef BEAT_SYNC_EN
  logic sync_hit;
  assign sync_hit = running && sync_pulse;
  assign tick_now = running && (wrap || (sync_hit && cnt >= (active_period >> 3)));
  assign zero_cnt = tick_now || sync_hit;
`else
  logic unused_sync;
  assign unused_sync = sync_pulse;
  assign tick_now    = running && wrap;
  assign zero_cnt    = tick_now;
`endif
  bpm_period_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (start_div),
    .dividend (DIVIDEND),
    .divisor  (bpm_clamped),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );
  // tempo FSM: a zero BPM stops from any state, a fresh divide result starts the run
  always_comb begin
    next_state = state;
    next_state = stop ? IDLE
               : state == IDLE && start_div ? WAIT_DIV
               : state == WAIT_DIV && div_done ? RUN
               : state;
  end
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next_state;
  // period_cycles follows every finished divide, even while ticks run at the old rate
  always_ff @(posedge clk)
    if (reset || stop) period_cycles <= '0;
    else if (div_done) period_cycles <= quotient;
  // phase counter and tick outputs; a new period only takes effect on a tick so beats never glitch
  always_ff @(posedge clk)
    if (reset || stop) begin
      cnt           <= '0;
      active_period <= '0;
      beat_tick     <= 1'b0;
      bar_start     <= 1'b0;
      beat_in_bar   <= 4'd0;
    end else if (state == WAIT_DIV && div_done) begin
      cnt           <= '0;
      active_period <= quotient;
      beat_tick     <= 1'b0;
      bar_start     <= 1'b0;
    end else begin
      beat_tick <= tick_now;
      bar_start <= tick_now && bar_next == 4'd0;
      cnt       <= !running || zero_cnt ? '0 : cnt + 32'd1;
      if (tick_now) begin
        beat_in_bar   <= bar_next;
        active_period <= period_cycles;
      end
    end
endmodule

// File: tb/tb_bpm_beat_generator.sv
// tb_bpm_beat_generator: randomized scoreboard bench for bpm_beat_generator at CLK_HZ=1000
module tb_bpm_beat_generator;
  typedef struct { int t; int bar; bit bs; } tick_t;
  typedef struct { int t; int v; } per_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bpm_in = 16'd0;
  logic        bpm_valid = 1'b0;
  logic        sync_pulse = 1'b0;
  logic        bpm_ready, beat_tick, bar_start, running;
  logic [3:0]  beat_in_bar;
  logic [31:0] period_cycles;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int exp_per = 0;
  tick_t tq[$];
  per_t  pq[$];

  bpm_beat_generator #(.CLK_HZ(1000), .MIN_BPM(40), .MAX_BPM(240), .BEATS_PER_BAR(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .bpm_in        (bpm_in),
    .bpm_valid     (bpm_valid),
    .bpm_ready     (bpm_ready),
    .sync_pulse    (sync_pulse),
    .beat_tick     (beat_tick),
    .bar_start     (bar_start),
    .beat_in_bar   (beat_in_bar),
    .period_cycles (period_cycles),
    .running       (running)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %0d want %0d", n, cyc, got, want);
    end
  endtask

  function automatic int clampb(input int b);
    return b < 40 ? 40 : b > 240 ? 240 : b;
  endfunction

  // reference: lay out every expected tick from the tempo rules
  task automatic plan(input int t0, input int p1, input int t2, input int p2, input int stop, input int se);
    int t, per, bar, nt;
    bit synced;
    t = t0; per = p1; bar = 0; synced = 0;
    forever begin
      nt = t + per;
      if (!synced && se > t && se < nt) begin
        synced = 1;
        if (se - 1 - t < per / 8) begin
          t = se;
          continue;
        end
        nt = se;
      end
      if (nt >= stop) break;
      bar = (bar + 1) % 4;
      tq.push_back(tick_t'{t: nt, bar: bar, bs: (bar == 0)});
      if (t2 >= 0 && nt > t2 + 33) per = p2;
      t = nt;
    end
  endtask

  // monitor: compares tick train and period_cycles against the scoreboard each cycle
  always @(negedge clk) begin
    if (tq.size() > 0 && tq[0].t == cyc) begin
      chk("tick", beat_tick, 1);
      chk("tick_bar", beat_in_bar, tq[0].bar);
      chk("tick_bar_start", bar_start, tq[0].bs);
      void'(tq.pop_front());
    end else begin
      chk("no_tick", beat_tick, 0);
      chk("no_bar_start", bar_start, 0);
    end
    if (pq.size() > 0 && pq[0].t == cyc) begin
      exp_per = pq[0].v;
      void'(pq.pop_front());
    end
    chk("period_cycles", period_cycles, exp_per);
  end

  // one run: accept b1, optional tempo change to b2 after chg cycles of running, optional sync pulse, then stop
  task automatic scenario(input int b1, input int b2, input int chg, input int dur, input int se_rel);
    int t1, t2, p1, p2, stop, se, se_model;
    p1 = 60000 / clampb(b1);
    p2 = b2 > 0 ? 60000 / clampb(b2) : 0;
    t1 = cyc + 1;
    t2 = b2 > 0 ? t1 + 33 + chg : -1;
    stop = (t2 >= 0 ? t2 + 33 : t1 + 33) + dur;
    se = se_rel >= 0 ? t1 + 33 + se_rel : -1;
`ifdef BEAT_SYNC_EN
    se_model = se;
`else
    se_model = -1;
`endif
    pq.push_back(per_t'{t: t1 + 33, v: p1});
    if (t2 >= 0) pq.push_back(per_t'{t: t2 + 33, v: p2});
    pq.push_back(per_t'{t: stop, v: 0});
    plan(t1 + 33, p1, t2, p2, stop, se_model);
    chk("ready_idle", bpm_ready, 1);
    bpm_in = 16'(b1);
    bpm_valid = 1'b1;
    while (cyc < stop + 20) begin
      @(negedge clk);
      bpm_valid = (cyc == t1 + 9) || (cyc == t2 - 1) || (cyc == stop - 1);
      bpm_in = cyc == t1 + 9 ? 16'd200 : cyc == stop - 1 ? 16'd0 : 16'(b2);
      sync_pulse = cyc == se - 1;
      chk("bpm_ready", bpm_ready, !((cyc >= t1 && cyc <= t1 + 32) || (t2 >= 0 && cyc >= t2 && cyc <= t2 + 32)));
      chk("running", running, cyc >= t1 + 33 && cyc < stop);
      if (cyc == stop) chk("bar_at_stop", beat_in_bar, 0);
    end
    bpm_valid = 1'b0;
    sync_pulse = 1'b0;
  endtask

  initial begin
    int b1, b2;
    repeat (3) @(negedge clk);
    chk("rst_ready", bpm_ready, 1);
    chk("rst_running", running, 0);
    chk("rst_tick", beat_tick, 0);
    chk("rst_bar_start", bar_start, 0);
    chk("rst_bar", beat_in_bar, 0);
    chk("rst_period", period_cycles, 0);
    reset = 1'b0;
    @(negedge clk);
    scenario(120, 0, 0, 6 * 500 + 7, -1);
    scenario(300, 0, 0, 5 * 250 + 3, -1);
    scenario(10, 0, 0, 4 * 1500 + 11, -1);
    scenario(120, 60, $urandom_range(100, 900), 5000, -1);
    scenario(120, 0, 0, 2500, 500 + 301);
    scenario(120, 0, 0, 2500, 500 + 21);
    repeat (2) begin
      b1 = $urandom_range(1, 400);
      b2 = $urandom_range(0, 1) == 1 ? $urandom_range(1, 400) : 0;
      scenario(b1, b2, $urandom_range(1, 1500), $urandom_range(1000, 6000), -1);
    end
    bpm_in = 16'd150;
    bpm_valid = 1'b1;
    @(negedge clk);
    bpm_valid = 1'b0;
    chk("mid_div_busy", bpm_ready, 0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", bpm_ready, 1);
    chk("abort_running", running, 0);
    chk("abort_tick", beat_tick, 0);
    chk("abort_bar", beat_in_bar, 0);
    chk("abort_period", period_cycles, 0);
    scenario(100, 0, 0, 3 * 600 + 5, -1);
    chk("ticks_left", tq.size(), 0);
    chk("periods_left", pq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
